// File: rtl/reveal_engine.sv
// reveal_engine: minesweeper reveal/flag controller with a multi-pass scanning flood fill.
module reveal_engine (
  input  logic         clk,
  input  logic         rst,
  input  logic         map_ready,
  input  logic [255:0] map_flat,
  input  logic [2:0]   cursor_x,
  input  logic [2:0]   cursor_y,
  input  logic         reveal,
  input  logic         flag,
  output logic [63:0]  revealed,
  output logic [63:0]  flagged,
  output logic         busy,
  output logic         game_over,
  output logic         game_won
);
  localparam logic [2:0] WAIT_MAP = 3'd0;
  localparam logic [2:0] IDLE     = 3'd1;
  localparam logic [2:0] SCAN     = 3'd2;
  localparam logic [2:0] LOST     = 3'd3;
  localparam logic [2:0] WON      = 3'd4;
  localparam logic [63:0] COL0 = 64'h0101_0101_0101_0101;
  localparam logic [63:0] COL7 = 64'h8080_8080_8080_8080;
  logic [2:0]   state_q, state_d;
  logic [255:0] board_q, board_d;
  logic [63:0]  rev_q, rev_d, flag_q, flag_d;
  logic [5:0]   idx_q, idx_d;
  logic         chg_q, chg_d;
  logic         busy_q, over_q, won_q;
  logic [63:0]  mine, oh, nb, grow;
  logic [5:0]   sel;
  logic [3:0]   sel_v, scan_v;
  assign sel    = {cursor_y, cursor_x};
  assign sel_v  = board_q[{sel, 2'b00} +: 4];
  assign scan_v = board_q[{idx_q, 2'b00} +: 4];
  assign oh     = 64'd1 << idx_q;
  // Shifted one-hot gives each neighbour; column masks kill row wrap-around.
  assign nb = ((oh >> 1) & ~COL7) | ((oh << 1) & ~COL0) | (oh >> 8) | (oh << 8) |
              ((oh >> 9) & ~COL7) | ((oh >> 7) & ~COL0) | ((oh << 7) & ~COL7) | ((oh << 9) & ~COL0);
  assign grow = (rev_q[idx_q] && scan_v == 4'd0) ? (nb & ~rev_q & ~flag_q) : 64'd0;
  always_comb begin
    for (int i = 0; i < 64; i++) mine[i] = board_q[4*i +: 4] == 4'hF;
  end
  always_comb begin
    state_d = state_q;
    board_d = board_q;
    rev_d   = rev_q;
    flag_d  = flag_q;
    idx_d   = idx_q;
    chg_d   = chg_q;
    if (state_q == WAIT_MAP) begin
      if (map_ready) begin
        board_d = map_flat;
        state_d = IDLE;
      end
    end else if (!map_ready) begin
      state_d = WAIT_MAP;
      rev_d   = '0;
      flag_d  = '0;
    end else if (state_q == IDLE) begin
      if (&(rev_q | mine)) state_d = WON;
      else if (reveal) begin
        if (!rev_q[sel] && !flag_q[sel]) begin
          rev_d[sel] = 1'b1;
          state_d    = sel_v == 4'hF ? LOST : sel_v == 4'd0 ? SCAN : IDLE;
          idx_d      = '0;
          chg_d      = 1'b0;
        end
      end else if (flag && !rev_q[sel]) flag_d[sel] = !flag_q[sel];
    end else if (state_q == SCAN) begin
      rev_d = rev_q | grow;
      idx_d = idx_q + 6'd1;
      chg_d = (chg_q || |grow) && idx_q != 6'd63;
      if (idx_q == 6'd63 && !chg_q && !(|grow)) state_d = IDLE;
    end else if (state_q == LOST) rev_d = rev_q | mine;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= WAIT_MAP;
      board_q <= '0;
      rev_q   <= '0;
      flag_q  <= '0;
      idx_q   <= '0;
      chg_q   <= 1'b0;
      busy_q  <= 1'b0;
      over_q  <= 1'b0;
      won_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      board_q <= board_d;
      rev_q   <= rev_d;
      flag_q  <= flag_d;
      idx_q   <= idx_d;
      chg_q   <= chg_d;
      busy_q  <= state_d == SCAN;
      over_q  <= state_d == LOST;
      won_q   <= state_d == WON;
    end
  end
  assign revealed  = rev_q;
  assign flagged   = flag_q;
  assign busy      = busy_q;
  assign game_over = over_q;
  assign game_won  = won_q;
endmodule

// File: tb/tb_reveal_engine.sv
// tb_reveal_engine: directed vector table plus hand sequences for fill, loss, win and reset.
module tb_reveal_engine;
  logic         clk, rst, map_ready, reveal, flag;
  logic [255:0] map_flat, map_a, map_b;
  logic [2:0]   cursor_x, cursor_y;
  logic [63:0]  revealed, flagged;
  logic         busy, game_over, game_won;
  int           nchk, nfail, n;
  typedef struct {
    logic        r, f;
    logic [2:0]  x, y;
    logic [63:0] er, ef;
  } vec_t;
  vec_t tv[12];
  reveal_engine dut (
    .clk(clk), .rst(rst), .map_ready(map_ready), .map_flat(map_flat),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .reveal(reveal), .flag(flag),
    .revealed(revealed), .flagged(flagged), .busy(busy),
    .game_over(game_over), .game_won(game_won)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic pulse(input logic r, input logic f, input logic [2:0] x, input logic [2:0] y);
    reveal = r; flag = f; cursor_x = x; cursor_y = y;
    @(negedge clk);
    reveal = 1'b0; flag = 1'b0;
  endtask
  task automatic reload(input logic [255:0] m);
    map_flat = m; map_ready = 1'b0;
    @(negedge clk);
    map_ready = 1'b1;
    @(negedge clk);
  endtask
  task automatic wait_fill(output int cyc);
    cyc = 0;
    while (busy && cyc < 4200) begin
      @(negedge clk);
      cyc++;
    end
    chk("fill_done", {63'd0, busy}, 64'd0);
    chk("fill_len_ok", {63'd0, cyc <= 4160}, 64'd1);
  endtask
  initial begin
    nchk = 0; nfail = 0;
    map_a = '0;
    map_a[3:0] = 4'hF; map_a[7:4] = 4'd1; map_a[35:32] = 4'd1; map_a[39:36] = 4'd1;
    map_b = map_a;
    map_b[23:20] = 4'hF;
    tv[0]  = '{1'b0, 1'b1, 3'd2, 3'd0, 64'h0,   64'h4};
    tv[1]  = '{1'b1, 1'b0, 3'd1, 3'd0, 64'h2,   64'h4};
    tv[2]  = '{1'b1, 1'b1, 3'd1, 3'd1, 64'h202, 64'h4};
    tv[3]  = '{1'b0, 1'b1, 3'd1, 3'd1, 64'h202, 64'h4};
    tv[4]  = '{1'b1, 1'b0, 3'd1, 3'd0, 64'h202, 64'h4};
    tv[5]  = '{1'b1, 1'b0, 3'd2, 3'd0, 64'h202, 64'h4};
    tv[6]  = '{1'b0, 1'b1, 3'd2, 3'd0, 64'h202, 64'h0};
    tv[7]  = '{1'b0, 1'b1, 3'd0, 3'd1, 64'h202, 64'h100};
    tv[8]  = '{1'b1, 1'b0, 3'd0, 3'd1, 64'h202, 64'h100};
    tv[9]  = '{1'b0, 1'b1, 3'd0, 3'd1, 64'h202, 64'h0};
    tv[10] = '{1'b1, 1'b0, 3'd0, 3'd1, 64'h302, 64'h0};
    tv[11] = '{1'b0, 1'b0, 3'd7, 3'd7, 64'h302, 64'h0};
    rst = 1'b1; map_ready = 1'b0; map_flat = map_a; reveal = 1'b0; flag = 1'b0;
    cursor_x = '0; cursor_y = '0;
    repeat (2) @(negedge clk);
    chk("rst_revealed", revealed, 64'h0);
    chk("rst_flagged", flagged, 64'h0);
    chk("rst_flags", {61'd0, busy, game_over, game_won}, 64'h0);
    rst = 1'b0;
    @(negedge clk);
    map_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      pulse(tv[i].r, tv[i].f, tv[i].x, tv[i].y);
      chk($sformatf("vec%0d_revealed", i), revealed, tv[i].er);
      chk($sformatf("vec%0d_flagged", i), flagged, tv[i].ef);
      chk($sformatf("vec%0d_status", i), {61'd0, busy, game_over, game_won}, 64'h0);
    end
    map_flat = map_b; map_ready = 1'b0;
    @(negedge clk);
    chk("drop_revealed", revealed, 64'h0);
    chk("drop_flagged", flagged, 64'h0);
    map_ready = 1'b1;
    @(negedge clk);
    pulse(1'b1, 1'b0, 3'd5, 3'd0);
    chk("relatch_mine_rev", revealed, 64'h20);
    chk("relatch_over", {63'd0, game_over}, 64'd1);
    @(negedge clk);
    chk("lost_mask", revealed, 64'h21);
    pulse(1'b1, 1'b0, 3'd1, 3'd0);
    chk("lost_ignore", revealed, 64'h21);
    reload(map_a);
    chk("reload_over_clr", {63'd0, game_over}, 64'd0);
    pulse(1'b1, 1'b0, 3'd0, 3'd0);
    chk("mine_rev", revealed, 64'h1);
    chk("mine_over", {63'd0, game_over}, 64'd1);
    @(negedge clk);
    pulse(1'b1, 1'b0, 3'd7, 3'd7);
    chk("mine_hold", revealed, 64'h1);
    chk("mine_nobusy", {63'd0, busy}, 64'd0);
    reload(map_a);
    pulse(1'b0, 1'b1, 3'd2, 3'd0);
    chk("flag2", flagged, 64'h4);
    pulse(1'b1, 1'b0, 3'd7, 3'd7);
    chk("flag_fill_busy", {63'd0, busy}, 64'd1);
    wait_fill(n);
    chk("flag_fill_rev", revealed, 64'hFFFF_FFFF_FFFF_FFFA);
    repeat (3) @(negedge clk);
    chk("flag_fill_nowin", {63'd0, game_won}, 64'd0);
    pulse(1'b0, 1'b1, 3'd2, 3'd0);
    chk("unflag2", flagged, 64'h0);
    pulse(1'b1, 1'b0, 3'd2, 3'd0);
    wait_fill(n);
    @(negedge clk);
    chk("late_win", {63'd0, game_won}, 64'd1);
    chk("late_win_rev", revealed, 64'hFFFF_FFFF_FFFF_FFFE);
    reload(map_a);
    pulse(1'b1, 1'b0, 3'd7, 3'd7);
    repeat (5) @(negedge clk);
    chk("scan_busy", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    #1;
    chk("midscan_rst_rev", revealed, 64'h0);
    chk("midscan_rst_flags", {61'd0, busy, game_over, game_won}, 64'h0);
    map_ready = 1'b0;
    #99;
    rst = 1'b0;
    @(negedge clk);
    pulse(1'b1, 1'b0, 3'd7, 3'd7);
    chk("wait_map_ignore", {busy, revealed}, 65'h0);
    map_ready = 1'b1;
    @(negedge clk);
    pulse(1'b1, 1'b0, 3'd7, 3'd7);
    chk("fill_busy", {63'd0, busy}, 64'd1);
    wait_fill(n);
    chk("fill_rev", revealed, 64'hFFFF_FFFF_FFFF_FFFE);
    @(negedge clk);
    chk("fill_won", {63'd0, game_won}, 64'd1);
    pulse(1'b0, 1'b1, 3'd0, 3'd0);
    chk("won_ignore_flag", flagged, 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
    $finish;
  end
endmodule
